// File: rtl/pipe_pkg.sv
// Shared fetch-stage constants and the fetch controller state type.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PC_INC = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    MISS       = 2'd2,
    MISS_REDIR = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority select of the redirect source (jalr_e > br_e > jal_d).
// Ports:
//   jal_d/jal_target_d, br_e/br_target_e, jalr_e/jalr_target_e : redirect sources
//   redirect_c  : any redirect requested this cycle
//   target_c    : selected target with bits [1:0] forced to zero
//   misalign_c  : selected raw target had bit 1 set
module pc_redirect_mux
  import pipe_pkg::*;
(
  input  logic            jal_d,
  input  logic [XLEN-1:0] jal_target_d,
  input  logic            br_e,
  input  logic [XLEN-1:0] br_target_e,
  input  logic            jalr_e,
  input  logic [XLEN-1:0] jalr_target_e,
  output logic            redirect_c,
  output logic [XLEN-1:0] target_c,
  output logic            misalign_c
);

  logic [XLEN-1:0] raw_target;

  // Older EX-stage redirects beat the younger ID-stage JAL.
  always_comb begin
    raw_target = jal_target_d;
    if (jalr_e) begin
      raw_target = jalr_target_e;
    end else if (br_e) begin
      raw_target = br_target_e;
    end
  end

  assign redirect_c = jalr_e | br_e | jal_d;
  assign target_c   = {raw_target[XLEN-1:2], 2'b00};
  assign misalign_c = redirect_c & raw_target[1];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC sequencing controller: picks the next PC, drives the PC
// register's enable/clear and holds fetch across instruction memory waits,
// remembering any redirect that lands while a fetch is outstanding.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   pc_f              : current PC fed back from the PC register
//   stall_f           : hold IF (overridden by redirects)
//   jal_d/br_e/jalr_e + targets : redirect requests
//   imem_ready        : instruction memory delivers data this cycle
//   pc_next, pc_en, pc_clear : PC register controls
//   fetch_valid       : IF instruction valid this cycle
//   misalign          : one-cycle pulse after a redirect with target[1] set
//   state_o           : FSM state for debug
module pc_fetch_ctrl
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_f,
  input  logic            stall_f,
  input  logic            jal_d,
  input  logic [XLEN-1:0] jal_target_d,
  input  logic            br_e,
  input  logic [XLEN-1:0] br_target_e,
  input  logic            jalr_e,
  input  logic [XLEN-1:0] jalr_target_e,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_en,
  output logic            pc_clear,
  output logic            fetch_valid,
  output logic            misalign,
  output logic [1:0]      state_o
);

  fetch_state_t    state, state_nxt;
  logic            pend_vld, pend_vld_nxt;
  logic [XLEN-1:0] pend_pc, pend_pc_nxt;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            target_odd;
  logic [XLEN-1:0] seq_pc;

  pc_redirect_mux u_redirect_mux (
    .jal_d         (jal_d),
    .jal_target_d  (jal_target_d),
    .br_e          (br_e),
    .br_target_e   (br_target_e),
    .jalr_e        (jalr_e),
    .jalr_target_e (jalr_target_e),
    .redirect_c    (redirect),
    .target_c      (target),
    .misalign_c    (target_odd)
  );

  assign seq_pc  = pc_f + XLEN'(PC_INC);
  assign state_o = state;

  // State, pending-redirect and misalign flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pend_vld <= 1'b0;
      pend_pc  <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_vld <= pend_vld_nxt;
      pend_pc  <= pend_pc_nxt;
      misalign <= target_odd;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt    = state;
    pend_vld_nxt = pend_vld;
    pend_pc_nxt  = pend_pc;
    pc_next      = seq_pc;
    pc_en        = 1'b0;
    pc_clear     = 1'b0;
    fetch_valid  = 1'b0;

    case (state)
      BOOT: begin
        pc_next   = RESET_PC;
        pc_en     = 1'b1;
        pc_clear  = (RESET_PC == '0);
        state_nxt = RUN;
      end

      RUN: begin
        if (redirect) begin
          // The word at pc_f is wrong-path once a redirect fires.
          if (imem_ready) begin
            pc_next = target;
            pc_en   = 1'b1;
          end else begin
            pend_pc_nxt  = target;
            pend_vld_nxt = 1'b1;
            state_nxt    = MISS_REDIR;
          end
        end else if (!imem_ready) begin
          state_nxt = MISS;
        end else begin
          fetch_valid = 1'b1;
          pc_en       = !stall_f;
        end
      end

      MISS: begin
        if (redirect) begin
          pend_pc_nxt  = target;
          pend_vld_nxt = 1'b1;
          state_nxt    = MISS_REDIR;
        end else if (imem_ready) begin
          fetch_valid = 1'b1;
          pc_en       = !stall_f;
          state_nxt   = RUN;
        end
      end

      MISS_REDIR: begin
        // Returning word is stale; a same-cycle redirect is younger than pend.
        if (imem_ready && pend_vld) begin
          pc_next      = redirect ? target : pend_pc;
          pc_en        = 1'b1;
          pend_vld_nxt = 1'b0;
          state_nxt    = RUN;
        end else if (redirect) begin
          pend_pc_nxt = target;
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_f;
  logic        stall_f = 0, jal_d = 0, br_e = 0, jalr_e = 0, imem_ready = 1;
  logic [31:0] jal_target_d = 0, br_target_e = 0, jalr_target_e = 0;
  logic [31:0] pc_next;
  logic        pc_en, pc_clear, fetch_valid, misalign;
  logic [1:0]  state_o;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: mode flags, a pending-redirect slot and the expected PC.
  logic        m_boot, m_miss, m_pend, m_mis;
  logic [31:0] m_pend_pc, m_pc;
  logic        n_boot, n_miss, n_pend, n_mis;
  logic [31:0] n_pend_pc, n_pc;
  logic        e_en, e_clear, e_fv;
  logic [31:0] e_next;
  logic [1:0]  e_state;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_f          (pc_f),
    .stall_f       (stall_f),
    .jal_d         (jal_d),
    .jal_target_d  (jal_target_d),
    .br_e          (br_e),
    .br_target_e   (br_target_e),
    .jalr_e        (jalr_e),
    .jalr_target_e (jalr_target_e),
    .imem_ready    (imem_ready),
    .pc_next       (pc_next),
    .pc_en         (pc_en),
    .pc_clear      (pc_clear),
    .fetch_valid   (fetch_valid),
    .misalign      (misalign),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  // The PC register the controller steers.
  logic [31:0] pc_reg = 32'hdead_beec;
  always @(posedge clk) begin
    if (pc_clear) pc_reg <= 32'h0;
    else if (pc_en) pc_reg <= pc_next;
  end
  assign pc_f = pc_reg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_miss = 0; m_pend = 0; m_pend_pc = 0; m_mis = 0; m_pc = 0;
  endtask

  // Expected outputs for this cycle and the model state after the next edge.
  task automatic model_eval();
    logic        rd;
    logic [31:0] raw, aln;
    rd  = jalr_e | br_e | jal_d;
    raw = jalr_e ? jalr_target_e : (br_e ? br_target_e : jal_target_d);
    aln = raw & 32'hffff_fffc;
    e_en = 0; e_clear = 0; e_fv = 0; e_next = m_pc + 32'd4;
    n_boot = 0; n_miss = m_miss; n_pend = m_pend; n_pend_pc = m_pend_pc;
    n_mis = rd & raw[1];
    if (m_boot) begin
      e_state = 0; e_en = 1; e_clear = (RST_PC == 0); e_next = RST_PC; n_miss = 0; n_pend = 0;
    end else if (m_pend) begin
      e_state = 3;
      if (imem_ready) begin
        e_en = 1; e_next = rd ? aln : m_pend_pc; n_pend = 0; n_miss = 0;
      end else if (rd) n_pend_pc = aln;
    end else if (m_miss) begin
      e_state = 2;
      if (rd) begin n_pend = 1; n_pend_pc = aln; n_miss = 0; end
      else if (imem_ready) begin e_fv = 1; e_en = !stall_f; n_miss = 0; end
    end else begin
      e_state = 1;
      if (rd) begin
        if (imem_ready) begin e_en = 1; e_next = aln; end
        else begin n_pend = 1; n_pend_pc = aln; end
      end else if (!imem_ready) n_miss = 1;
      else begin e_fv = 1; e_en = !stall_f; end
    end
    n_pc = e_en ? e_next : m_pc;
  endtask

  // One clock cycle: drive, check, advance model. Entered and left at negedge.
  task automatic cyc(input logic st, input logic jl, input logic [31:0] jt,
                     input logic b, input logic [31:0] bt,
                     input logic jr, input logic [31:0] jrt, input logic rdy);
    stall_f = st; jal_d = jl; jal_target_d = jt; br_e = b; br_target_e = bt;
    jalr_e = jr; jalr_target_e = jrt; imem_ready = rdy;
    #1;
    model_eval();
    chk("pc_en", 32'(pc_en), 32'(e_en));
    chk("pc_clear", 32'(pc_clear), 32'(e_clear));
    chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    chk("state_o", 32'(state_o), 32'(e_state));
    chk("misalign", 32'(misalign), 32'(m_mis));
    if (!m_boot) chk("pc_f", pc_f, m_pc);
    if (e_en) chk("pc_next", pc_next, e_next);
    @(negedge clk);
    m_boot = n_boot; m_miss = n_miss; m_pend = n_pend; m_pend_pc = n_pend_pc;
    m_mis = n_mis; m_pc = n_pc;
  endtask

  task automatic seq(input logic rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    do_reset();
    // Boot cycle then sequential fetch 0,4,8,c.
    seq(1);
    chk("boot_pc", pc_reg, 32'h0);
    for (int i = 0; i < 4; i++) seq(1);
    chk("pc_at_10", pc_reg, 32'h10);
    // Two stall cycles hold the PC.
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("stall_hold", pc_reg, 32'h10);
    seq(1);
    chk("resume_14", pc_reg, 32'h14);
    // Branch beats JAL in the same cycle.
    cyc(0, 1, 32'h40, 1, 32'h80, 0, 0, 1);
    chk("br_over_jal", pc_reg, 32'h80);
    // Miss, JALR during the miss, another wait, then ready.
    seq(0);
    cyc(0, 0, 0, 0, 0, 1, 32'h200, 0);
    seq(0);
    chk("miss_redir_state", 32'(state_o), 32'd3);
    seq(1);
    chk("pend_release", pc_reg, 32'h200);
    // Misaligned JALR target.
    cyc(0, 0, 0, 0, 0, 1, 32'h102, 1);
    chk("misalign_pc", pc_reg, 32'h100);
    chk("misalign_pulse", 32'(misalign), 32'd1);
    seq(1);
    chk("misalign_drop", 32'(misalign), 32'd0);
    // Wrap past the top of the address space.
    cyc(0, 1, 32'hffff_fffc, 0, 0, 0, 0, 1);
    seq(1);
    chk("wrap", pc_reg, 32'h0);
    // Reset while a redirect is pending.
    cyc(0, 0, 0, 1, 32'h300, 0, 0, 0);
    chk("pend_state", 32'(state_o), 32'd3);
    do_reset();
    seq(1);
    seq(1);
    chk("post_reset_pc", pc_reg, RST_PC + 32'd4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc(($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0), $urandom,
          ($urandom_range(0, 6) == 0), $urandom,
          ($urandom_range(0, 7) == 0), $urandom,
          ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
